// File: rtl/next_pc_predictor.sv
`default_nettype none
// ============================================================================
// next_pc_predictor : fetch PC register with direct-mapped BTB + 2-bit counters
// Rev 1.0
// ============================================================================
module next_pc_predictor #(
  parameter int              XLEN      = 32,
  parameter int              BTB_DEPTH = 16,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pred_next,
  output logic            pred_taken,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_pred_next,
  input  logic [5:0]      ex_opcode,
  input  logic            ex_branch,
  input  logic            ex_jump,
  input  logic            ex_jal,
  input  logic            ex_jr,
  input  logic [XLEN-1:0] ex_ext_imm,
  input  logic [25:0]     ex_target,
  input  logic [XLEN-1:0] ex_rd1,
  input  logic [XLEN-1:0] ex_rd2,
  output logic            flush
);

  localparam int C_IDX  = $clog2(BTB_DEPTH);
  localparam int C_TAGW = XLEN - C_IDX - 2;
  localparam logic [5:0] C_OP_BEQ = 6'b000100;
  localparam logic [5:0] C_OP_BNE = 6'b000101;

  logic [XLEN-1:0]   pc_q, pc_d;
  logic              flush_q, flush_d;
  logic              valid_q [BTB_DEPTH];
  logic [C_TAGW-1:0] tag_q   [BTB_DEPTH];
  logic [XLEN-1:0]   tgt_q   [BTB_DEPTH];
  logic [1:0]        ctr_q   [BTB_DEPTH];

  // Fetch-side lookup
  logic [C_IDX-1:0]  f_idx;
  logic [C_TAGW-1:0] f_tag;
  logic              f_hit;

  assign f_idx      = pc_q[C_IDX+1:2];
  assign f_tag      = pc_q[XLEN-1:C_IDX+2];
  assign f_hit      = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign pred_taken = f_hit && ctr_q[f_idx][1];
  assign pred_next  = pred_taken ? tgt_q[f_idx] : pc_q + XLEN'(4);

  // Execute-side resolution
  logic [C_IDX-1:0]  e_idx;
  logic [C_TAGW-1:0] e_tag;
  logic              e_hit, cond, taken, mispredict, is_jmp;
  logic [XLEN-1:0]   p4, actual;
  logic [1:0]        ctr_nxt;

  assign e_idx  = ex_pc[C_IDX+1:2];
  assign e_tag  = ex_pc[XLEN-1:C_IDX+2];
  assign e_hit  = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
  assign p4     = ex_pc + XLEN'(4);
  assign cond   = ((ex_opcode == C_OP_BEQ) && (ex_rd1 == ex_rd2)) ||
                  ((ex_opcode == C_OP_BNE) && (ex_rd1 != ex_rd2));
  assign is_jmp = ex_jump | ex_jal | ex_jr;

  always_comb begin
    actual = p4;
    if (ex_jr)
      actual = ex_rd1;
    else if (ex_jump | ex_jal)
      actual = {ex_pc[XLEN-1:28], ex_target, 2'b00};
    else if (ex_branch && cond)
      actual = p4 + {ex_ext_imm[XLEN-3:0], 2'b00};
  end

  assign taken      = (actual != p4);
  assign mispredict = ex_valid && (actual != ex_pred_next);

  always_comb begin
    ctr_nxt = ctr_q[e_idx];
    if (taken && ctr_q[e_idx] != 2'b11)
      ctr_nxt = ctr_q[e_idx] + 2'd1;
    else if (!taken && ctr_q[e_idx] != 2'b00)
      ctr_nxt = ctr_q[e_idx] - 2'd1;
  end

  // A redirect from execute always beats a stall: the fetched stream is wrong anyway.
  always_comb begin
    pc_d    = pc_q;
    flush_d = 1'b0;
    if (mispredict) begin
      pc_d    = actual;
      flush_d = 1'b1;
    end else if (!stall) begin
      pc_d = pred_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      flush_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      flush_q <= flush_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BTB_DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (ex_valid) begin
      if (is_jmp) begin
        valid_q[e_idx] <= 1'b1;
        tag_q[e_idx]   <= e_tag;
        tgt_q[e_idx]   <= actual;
        ctr_q[e_idx]   <= 2'b11;
      end else if (ex_branch) begin
        if (e_hit) begin
          ctr_q[e_idx] <= ctr_nxt;
          if (taken)
            tgt_q[e_idx] <= actual;
        end else if (taken) begin
          valid_q[e_idx] <= 1'b1;
          tag_q[e_idx]   <= e_tag;
          tgt_q[e_idx]   <= actual;
          ctr_q[e_idx]   <= 2'b10;
        end
      end else if (e_hit && mispredict) begin
        // Non-control instruction predicted as taken: stale/aliased entry.
        valid_q[e_idx] <= 1'b0;
      end
    end
  end

  assign pc    = pc_q;
  assign flush = flush_q;

  logic unused_imm_hi;
  assign unused_imm_hi = &{1'b0, ex_ext_imm[XLEN-1:XLEN-2]};

endmodule
`default_nettype wire

// File: tb/tb_next_pc_predictor.sv
`default_nettype none
// Directed self-checking bench for next_pc_predictor (RESET_PC=0x100, 16 entries).
module tb_next_pc_predictor;
  logic        clk = 1'b0;
  logic        rst, stall, pred_taken, flush;
  logic [31:0] pc, pred_next;
  logic        ex_valid, ex_branch, ex_jump, ex_jal, ex_jr;
  logic [31:0] ex_pc, ex_pred_next, ex_ext_imm, ex_rd1, ex_rd2;
  logic [5:0]  ex_opcode;
  logic [25:0] ex_target;
  int          errors = 0;
  int          checks = 0;

  next_pc_predictor #(.XLEN(32), .BTB_DEPTH(16), .RESET_PC(32'h100)) dut (
    .clk(clk), .rst(rst), .stall(stall), .pc(pc), .pred_next(pred_next),
    .pred_taken(pred_taken), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_pred_next(ex_pred_next), .ex_opcode(ex_opcode), .ex_branch(ex_branch),
    .ex_jump(ex_jump), .ex_jal(ex_jal), .ex_jr(ex_jr), .ex_ext_imm(ex_ext_imm),
    .ex_target(ex_target), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr_ex();
    ex_valid = 0; ex_branch = 0; ex_jump = 0; ex_jal = 0; ex_jr = 0;
    ex_opcode = 6'd0; ex_ext_imm = 0; ex_target = 0; ex_rd1 = 0; ex_rd2 = 0;
  endtask

  task automatic branch(input logic [31:0] bpc, input logic [5:0] op, input logic [31:0] imm,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] pn);
    clr_ex();
    ex_valid = 1; ex_branch = 1; ex_pc = bpc; ex_opcode = op; ex_ext_imm = imm;
    ex_rd1 = a; ex_rd2 = b; ex_pred_next = pn;
    tick();
    clr_ex();
  endtask

  // Steer fetch to an address via a jr resolved at 0xF00C (BTB index 3).
  task automatic redirect(input logic [31:0] a);
    clr_ex();
    ex_valid = 1; ex_jr = 1; ex_pc = 32'hF00C; ex_pred_next = 32'hF010; ex_rd1 = a;
    tick();
    clr_ex();
  endtask

  initial begin
    rst = 1; stall = 0; ex_pc = 0; ex_pred_next = 0;
    clr_ex();
    tick(); tick();
    rst = 0;
    chk("reset_pc", pc, 32'h100);
    chk("reset_flush", {31'd0, flush}, 32'd0);
    // invalid execute slot with a bogus prediction must not redirect
    ex_jr = 1; ex_rd1 = 32'h9999; ex_pred_next = 32'h1234;
    tick();
    chk("free_pc1", pc, 32'h104);
    chk("free_nflush", {31'd0, flush}, 32'd0);
    clr_ex();
    tick();
    chk("free_pc2", pc, 32'h108);
    tick();
    chk("free_pc3", pc, 32'h10C);
    chk("free_ptaken", {31'd0, pred_taken}, 32'd0);

    // beq taken: 0x204 + 3*4 = 0x210, allocated with ctr=10
    branch(32'h200, 6'b000100, 32'd3, 32'd5, 32'd5, 32'h204);
    chk("beq_redir_pc", pc, 32'h210);
    chk("beq_flush", {31'd0, flush}, 32'd1);
    stall = 1;
    redirect(32'h200);
    chk("redir_pc", pc, 32'h200);
    chk("beq_hit_taken", {31'd0, pred_taken}, 32'd1);
    chk("beq_hit_next", pred_next, 32'h210);

    // counter walk with pc parked at 0x200: 10 ->11 ->10 ->01 ->00 ->00(+1)=01 ->10
    branch(32'h200, 6'b000100, 32'd3, 32'd5, 32'd5, 32'h210);
    chk("ctr11_flush", {31'd0, flush}, 32'd0);
    chk("ctr11_pc", pc, 32'h200);
    chk("ctr11_taken", {31'd0, pred_taken}, 32'd1);
    branch(32'h200, 6'b000100, 32'd3, 32'd5, 32'd6, 32'h204);
    chk("ctr10_taken", {31'd0, pred_taken}, 32'd1);
    chk("ctr10_nflush", {31'd0, flush}, 32'd0);
    branch(32'h200, 6'b000100, 32'd3, 32'd5, 32'd6, 32'h204);
    chk("ctr01_taken", {31'd0, pred_taken}, 32'd0);
    chk("ctr01_next", pred_next, 32'h204);
    branch(32'h200, 6'b000100, 32'd3, 32'd5, 32'd6, 32'h204);
    chk("ctr00_taken", {31'd0, pred_taken}, 32'd0);
    branch(32'h200, 6'b000100, 32'd3, 32'd7, 32'd7, 32'h210);
    chk("ctr00_sat_inc", {31'd0, pred_taken}, 32'd0);
    branch(32'h200, 6'b000100, 32'd3, 32'd7, 32'd7, 32'h210);
    chk("ctr10_again", {31'd0, pred_taken}, 32'd1);
    chk("ctr10_again_next", pred_next, 32'h210);

    // jr while stalled: mispredict wins over stall
    clr_ex();
    ex_valid = 1; ex_jr = 1; ex_pc = 32'h300; ex_pred_next = 32'h304; ex_rd1 = 32'h4000;
    tick();
    chk("jr_pc", pc, 32'h4000);
    chk("jr_flush", {31'd0, flush}, 32'd1);
    clr_ex();
    stall = 0;
    tick();
    chk("jr_flush_drop", {31'd0, flush}, 32'd0);
    chk("jr_then_seq", pc, 32'h4004);
    // j: {0x3, 26'h40, 00} = 0x30000100
    ex_valid = 1; ex_jump = 1; ex_pc = 32'h30000010; ex_target = 26'h40;
    ex_pred_next = 32'h30000014;
    tick();
    chk("j_pc", pc, 32'h30000100);
    clr_ex();

    // aliasing: 0x40 and 0x80 share index 0; second allocation replaces first
    stall = 1;
    branch(32'h40, 6'b000100, 32'd1, 32'd2, 32'd2, 32'h48);
    branch(32'h80, 6'b000101, 32'd1, 32'd1, 32'd2, 32'h88);
    redirect(32'h40);
    chk("alias_first_miss", {31'd0, pred_taken}, 32'd0);
    chk("alias_first_next", pred_next, 32'h44);
    redirect(32'h80);
    chk("alias_second_hit", {31'd0, pred_taken}, 32'd1);
    chk("alias_second_next", pred_next, 32'h88);
    // non-control instruction at 0x80 issued with the BTB target
    ex_valid = 1; ex_pc = 32'h80; ex_pred_next = 32'h88;
    tick();
    clr_ex();
    chk("nonctl_pc", pc, 32'h84);
    chk("nonctl_flush", {31'd0, flush}, 32'd1);
    redirect(32'h80);
    chk("nonctl_inval", {31'd0, pred_taken}, 32'd0);
    chk("nonctl_inval_next", pred_next, 32'h84);

    // wrap and reset during a flush cycle with a pending mispredict
    redirect(32'hFFFFFFFC);
    chk("wrap_next", pred_next, 32'h0);
    chk("wrap_flush", {31'd0, flush}, 32'd1);
    rst = 1;
    ex_valid = 1; ex_jr = 1; ex_pc = 32'h300; ex_pred_next = 32'h304; ex_rd1 = 32'h5000;
    tick();
    rst = 0;
    clr_ex();
    chk("rst_mid_pc", pc, 32'h100);
    chk("rst_mid_flush", {31'd0, flush}, 32'd0);
    redirect(32'h200);
    chk("rst_btb_cleared", {31'd0, pred_taken}, 32'd0);
    chk("rst_btb_next", pred_next, 32'h204);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
